// File: rtl/gp_trigger_fsm_if.sv
// Engine master port bundle for gp_trigger_fsm.
//   master : drives request (valid/addr/wr_data/rd0_wr1), samples ready and read return.
//   slave  : the engine side, mirror of master.
// Parameters: DATA_WIDTH (transaction data), TRANS_ADDR_WIDTH (transaction address).
interface gp_trigger_fsm_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int TRANS_ADDR_WIDTH = 8
);
  logic                        m_o_valid;
  logic [TRANS_ADDR_WIDTH-1:0] m_o_addr;
  logic [DATA_WIDTH-1:0]       m_o_wr_data;
  logic                        m_o_rd0_wr1;
  logic                        m_i_ready;
  logic [DATA_WIDTH-1:0]       m_i_rd_data;
  logic                        m_i_rd_valid;

  modport master (
    output m_o_valid, m_o_addr, m_o_wr_data, m_o_rd0_wr1,
    input  m_i_ready, m_i_rd_data, m_i_rd_valid
  );

  modport slave (
    input  m_o_valid, m_o_addr, m_o_wr_data, m_o_rd0_wr1,
    output m_i_ready, m_i_rd_data, m_i_rd_valid
  );
endinterface

// File: rtl/gp_trigger_fsm.sv
// gp_trigger_fsm: GP-engine sequencer. Fetches four trigger-source configs from
// the register file, watches four trigger inputs and, on a qualifying edge of an
// enabled source, issues one configured read or write on the engine master port.
// Config word: [31] EN, [30] POL (1 rising), [29] RD0_WR1, [23:16] ADDR, [15:0] WDATA.
// Optional feature macro: GP_TRIG_PEND_EN (edges are remembered in a pending
// register instead of being dropped when they cannot be serviced at once).
// Ports:
//   i_clk, i_rstn           clock, synchronous active-low reset
//   reg_rd_en/reg_rd_valid  config fetch handshake
//   rd_trig_s1..s4_config   source configs (latched on reg_rd_valid in LOAD)
//   i_trig, i_cfg_reload    trigger inputs (bit0 = source 1), re-fetch request
//   eng                     engine master port (gp_trigger_fsm_if.master)
//   o_src_id, o_rd_data     last serviced source, last captured read data
//   o_done, o_busy          action-complete pulse, not-ARMED flag
module gp_trigger_fsm #(
  parameter int DATA_WIDTH       = 32,
  parameter int TRANS_ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  output logic                  reg_rd_en,
  input  logic                  reg_rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_trig_s1_config,
  input  logic [DATA_WIDTH-1:0] rd_trig_s2_config,
  input  logic [DATA_WIDTH-1:0] rd_trig_s3_config,
  input  logic [DATA_WIDTH-1:0] rd_trig_s4_config,
  input  logic [3:0]            i_trig,
  input  logic                  i_cfg_reload,
  gp_trigger_fsm_if.master      eng,
  output logic [1:0]            o_src_id,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_done,
  output logic                  o_busy
);
  // Address is zero-extended into a width that fits both the 8-bit cfg field
  // and the master port, then truncated to the port.
  localparam int AXW = (TRANS_ADDR_WIDTH > 8) ? TRANS_ADDR_WIDTH : 8;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARMED, S_ISSUE, S_RD_WAIT, S_DONE} state_t;

  state_t state_q, state_d;

  logic [3:0][DATA_WIDTH-1:0] cfg_in;
  logic [3:0]       en_new;
  logic [3:0]       en_q, pol_q, rw_q;
  logic [3:0][7:0]  addr_q;
  logic [3:0][15:0] wd_q;
  logic [3:0]       trig_prev, rise, fall, edge_hit, cand;
  logic [1:0]       sel;
  logic             take, load_done;
  logic [AXW-1:0]   addr_ext;

  logic [TRANS_ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]       req_wd, rd_data_q;
  logic                        req_rw, valid_c;
  logic [1:0]                  src_q;
  logic                        unused_bits;

  assign cfg_in = {rd_trig_s4_config, rd_trig_s3_config, rd_trig_s2_config, rd_trig_s1_config};

  always_comb begin
    en_new = '0;
    for (int i = 0; i < 4; i++) en_new[i] = cfg_in[i][31];
  end

  assign rise     = i_trig & ~trig_prev;
  assign fall     = ~i_trig & trig_prev;
  assign edge_hit = en_q & ((pol_q & rise) | (~pol_q & fall));

`ifdef GP_TRIG_PEND_EN
  logic [3:0] pend_q, pend_d;
  assign cand = edge_hit | pend_q;
`else
  assign cand = edge_hit;
`endif

  // Lowest index wins.
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) if (cand[i]) sel = 2'(i);
  end

  assign load_done = (state_q == S_LOAD) && reg_rd_valid;
  // Reload has priority over a same-cycle candidate.
  assign take      = (state_q == S_ARMED) && !i_cfg_reload && (|cand);
  assign addr_ext  = AXW'(addr_q[sel]);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    reg_rd_en = 1'b0;
    valid_c   = 1'b0;
    o_done    = 1'b0;
    o_busy    = 1'b1;
    case (state_q)
      S_IDLE:    state_d = S_LOAD;
      S_LOAD: begin
        reg_rd_en = 1'b1;
        if (reg_rd_valid) state_d = S_ARMED;
      end
      S_ARMED: begin
        o_busy = 1'b0;
        if (i_cfg_reload) state_d = S_LOAD;
        else if (|cand)   state_d = S_ISSUE;
      end
      S_ISSUE: begin
        valid_c = 1'b1;
        if (eng.m_i_ready) state_d = req_rw ? S_DONE : S_RD_WAIT;
      end
      S_RD_WAIT: if (eng.m_i_rd_valid) state_d = S_DONE;
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_LOAD;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      trig_prev <= '0;
      en_q      <= '0;
      pol_q     <= '0;
      rw_q      <= '0;
      addr_q    <= '0;
      wd_q      <= '0;
      req_addr  <= '0;
      req_wd    <= '0;
      req_rw    <= 1'b0;
      src_q     <= 2'd0;
      rd_data_q <= '0;
    end else begin
      trig_prev <= i_trig;
      if (load_done) begin
        en_q <= en_new;
        for (int i = 0; i < 4; i++) begin
          pol_q[i]  <= cfg_in[i][30];
          rw_q[i]   <= cfg_in[i][29];
          addr_q[i] <= cfg_in[i][23:16];
          wd_q[i]   <= cfg_in[i][15:0];
        end
      end
      if (take) begin
        req_addr <= addr_ext[TRANS_ADDR_WIDTH-1:0];
        req_wd   <= DATA_WIDTH'(wd_q[sel]);
        req_rw   <= rw_q[sel];
        src_q    <= sel;
      end
      // Read data returning in the acceptance cycle is ignored: only RD_WAIT captures.
      if (state_q == S_RD_WAIT && eng.m_i_rd_valid) rd_data_q <= eng.m_i_rd_data;
    end
  end

`ifdef GP_TRIG_PEND_EN
  // Edges collect in every state; the serviced source clears on entry to ISSUE,
  // and sources disabled by a fresh config lose their pending bit.
  always_comb begin
    pend_d = pend_q | edge_hit;
    if (take)      pend_d[sel] = 1'b0;
    if (load_done) pend_d = pend_d & en_new;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) pend_q <= '0;
    else         pend_q <= pend_d;
  end
`endif

  assign eng.m_o_valid   = valid_c;
  assign eng.m_o_addr    = req_addr;
  assign eng.m_o_wr_data = req_wd;
  assign eng.m_o_rd0_wr1 = req_rw;
  assign o_src_id        = src_q;
  assign o_rd_data       = rd_data_q;

  // Reserved/upper cfg bits and spare address-extension bits are intentionally dropped.
  assign unused_bits = ^{cfg_in, addr_ext};
endmodule

// File: tb/tb_gp_trigger_fsm.sv
module tb_gp_trigger_fsm;
  localparam int DW = 32;
  localparam int AW = 8;

  logic              i_clk = 1'b0;
  logic              i_rstn = 1'b0;
  logic              reg_rd_en;
  logic              reg_rd_valid = 1'b0;
  logic [3:0][31:0]  cfg_drv = '0;
  logic [3:0]        i_trig = 4'h0;
  logic              i_cfg_reload = 1'b0;
  logic [1:0]        o_src_id;
  logic [DW-1:0]     o_rd_data;
  logic              o_done, o_busy;

  gp_trigger_fsm_if #(.DATA_WIDTH(DW), .TRANS_ADDR_WIDTH(AW)) bus ();

  gp_trigger_fsm #(.DATA_WIDTH(DW), .TRANS_ADDR_WIDTH(AW)) dut (
    .i_clk             (i_clk),
    .i_rstn            (i_rstn),
    .reg_rd_en         (reg_rd_en),
    .reg_rd_valid      (reg_rd_valid),
    .rd_trig_s1_config (cfg_drv[0]),
    .rd_trig_s2_config (cfg_drv[1]),
    .rd_trig_s3_config (cfg_drv[2]),
    .rd_trig_s4_config (cfg_drv[3]),
    .i_trig            (i_trig),
    .i_cfg_reload      (i_cfg_reload),
    .eng               (bus.master),
    .o_src_id          (o_src_id),
    .o_rd_data         (o_rd_data),
    .o_done            (o_done),
    .o_busy            (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference state: what the spec says the block has latched/remembered.
  logic [3:0][31:0] mcfg;
  logic [3:0]       mprev, mpend;
  logic [31:0]      mlast_rd;

  typedef struct {
    logic [3:0][31:0] cfg;
    logic [3:0]       prev;
    logic [3:0]       nxt;
    logic             exp_valid;
    logic [1:0]       exp_src;
    logic [7:0]       exp_addr;
    logic [31:0]      exp_wd;
    logic             exp_rw;
    logic [31:0]      rdata;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic en, input logic pol, input logic wr,
                                     input logic [7:0] a, input logic [15:0] wd);
    return {en, pol, wr, 5'b0, a, wd};
  endfunction

  task automatic do_reset(input logic [3:0] lvl);
    i_rstn = 1'b0;
    reg_rd_valid = 1'b0;
    i_cfg_reload = 1'b0;
    bus.m_i_ready = 1'b0;
    bus.m_i_rd_valid = 1'b0;
    i_trig = lvl;
    tick();
    tick();
    mcfg = '0;
    mpend = '0;
    mprev = lvl;
    mlast_rd = '0;
    i_rstn = 1'b1;
  endtask

  // Serve one config fetch; during the stall the config ports carry garbage.
  task automatic load_cfg(input logic [3:0][31:0] c, input int stall);
    int n = 0;
    while (reg_rd_en !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("load_req_seen", reg_rd_en, 1);
    cfg_drv = ~c;
    for (int k = 0; k < stall; k++) begin
      tick();
      chk("load_req_held", reg_rd_en, 1);
    end
    cfg_drv = c;
    reg_rd_valid = 1'b1;
    tick();
    reg_rd_valid = 1'b0;
    cfg_drv = ~c;
    mcfg = c;
    for (int i = 0; i < 4; i++) if (!c[i][31]) mpend[i] = 1'b0;
    chk("armed_after_load", o_busy, 0);
    chk("load_req_drop", reg_rd_en, 0);
  endtask

  // Drive the request through backpressure, acceptance, optional read return and DONE.
  task automatic complete(input logic [7:0] ea, input logic [31:0] ewd, input logic erw,
                          input int rdy, input int rdv, input logic [31:0] rdata,
                          input logic [1:0] esrc);
    for (int k = 0; k < rdy; k++) begin
      i_cfg_reload = (k == 1);
      tick();
      chk("bp_valid", bus.m_o_valid, 1);
      chk("bp_addr", bus.m_o_addr, ea);
      chk("bp_wdata", bus.m_o_wr_data, ewd);
      chk("bp_rw", bus.m_o_rd0_wr1, erw);
    end
    i_cfg_reload = 1'b0;
    bus.m_i_ready = 1'b1;
    bus.m_i_rd_valid = 1'b1;
    bus.m_i_rd_data = ~rdata;
    tick();
    bus.m_i_ready = 1'b0;
    bus.m_i_rd_valid = 1'b0;
    chk("accept_single", bus.m_o_valid, 0);
    if (erw) begin
      chk("wr_done", o_done, 1);
    end else begin
      chk("rd_no_early_done", o_done, 0);
      chk("rd_ignored_at_accept", o_rd_data, mlast_rd);
      for (int k = 0; k < rdv; k++) begin
        tick();
        chk("rd_wait_no_done", o_done, 0);
      end
      bus.m_i_rd_valid = 1'b1;
      bus.m_i_rd_data = rdata;
      tick();
      bus.m_i_rd_valid = 1'b0;
      mlast_rd = rdata;
      chk("rd_done", o_done, 1);
      chk("rd_data", o_rd_data, rdata);
    end
    chk("done_src", o_src_id, esrc);
    tick();
    chk("done_one_cycle", o_done, 0);
    chk("refetch_after_done", reg_rd_en, 1);
  endtask

  // One ARMED cycle with trigger value tnew; expectation from the edge/EN/POL rules.
  task automatic run_action(input logic [3:0] tnew, input int rdy, input int rdv,
                            input logic [31:0] rdata, output bit acted);
    logic [3:0] e, c;
    int w;
    for (int i = 0; i < 4; i++) begin
      if (!mcfg[i][31])     e[i] = 1'b0;
      else if (mcfg[i][30]) e[i] = tnew[i] && !mprev[i];
      else                  e[i] = !tnew[i] && mprev[i];
    end
    c = e;
`ifdef GP_TRIG_PEND_EN
    c = e | mpend;
    mpend = mpend | e;
`endif
    i_trig = tnew;
    mprev = tnew;
    tick();
    acted = 0;
    if (c == 4'h0) begin
      chk("no_action_valid", bus.m_o_valid, 0);
      chk("no_action_armed", o_busy, 0);
      return;
    end
    w = 0;
    while (!c[w]) w++;
`ifdef GP_TRIG_PEND_EN
    mpend[w] = 1'b0;
`endif
    chk("act_valid", bus.m_o_valid, 1);
    chk("act_src", o_src_id, w);
    chk("act_addr", bus.m_o_addr, mcfg[w][23:16]);
    chk("act_wdata", bus.m_o_wr_data, {16'h0, mcfg[w][15:0]});
    chk("act_rw", bus.m_o_rd0_wr1, mcfg[w][29]);
    complete(mcfg[w][23:16], {16'h0, mcfg[w][15:0]}, mcfg[w][29], rdy, rdv, rdata, 2'(w));
    acted = 1;
  endtask

  initial begin
    logic [3:0][31:0] c;
    bit acted;

    bus.m_i_ready = 1'b0;
    bus.m_i_rd_valid = 1'b0;
    bus.m_i_rd_data = '0;

    vt[0] = '{{32'h0, 32'h0, 32'h0, mk(1,1,1,8'h04,16'h1234)}, 4'h0, 4'h1, 1, 2'd0, 8'h04, 32'h1234, 1, 32'h0};
    vt[1] = '{{32'h0, mk(1,0,0,8'h0C,16'h0), 32'h0, 32'h0}, 4'h4, 4'h0, 1, 2'd2, 8'h0C, 32'h0, 0, 32'hDEADBEEF};
    vt[2] = '{{mk(1,1,1,8'h43,16'h4444), 32'h0, mk(1,1,1,8'h21,16'h2222), 32'h0}, 4'h0, 4'hA, 1, 2'd1, 8'h21, 32'h2222, 1, 32'h0};
    vt[3] = '{{32'h0, 32'h0, 32'h0, mk(0,1,1,8'h04,16'h1234)}, 4'h0, 4'h1, 0, 2'd0, 8'h00, 32'h0, 0, 32'h0};
    vt[4] = '{{32'h0, 32'h0, 32'h0, mk(1,1,1,8'h04,16'h1234)}, 4'h1, 4'h0, 0, 2'd0, 8'h00, 32'h0, 0, 32'h0};
    vt[5] = '{{mk(1,1,0,8'h40,16'h4), mk(1,1,0,8'h30,16'h3), mk(1,1,0,8'h20,16'h2), mk(1,1,0,8'h10,16'h1)},
              4'h3, 4'hF, 1, 2'd2, 8'h30, 32'h3, 0, 32'h12345678};
    vt[6] = '{{mk(1,1,0,8'h40,16'h4), mk(1,1,0,8'h30,16'h3), mk(1,1,0,8'h20,16'h2), mk(1,1,0,8'h10,16'h1)},
              4'hF, 4'hF, 0, 2'd0, 8'h00, 32'h0, 0, 32'h0};
    vt[7] = '{{mk(1,0,1,8'hFF,16'hFFFF) | 32'h1F00_0000, 32'h0, 32'h0, 32'h0}, 4'h8, 4'h0, 1, 2'd3, 8'hFF, 32'hFFFF, 1, 32'h0};

    // Reset state
    tick();
    tick();
    chk("rst_reg_rd_en", reg_rd_en, 0);
    chk("rst_valid", bus.m_o_valid, 0);
    chk("rst_addr", bus.m_o_addr, 0);
    chk("rst_wdata", bus.m_o_wr_data, 0);
    chk("rst_rw", bus.m_o_rd0_wr1, 0);
    chk("rst_src", o_src_id, 0);
    chk("rst_rd_data", o_rd_data, 0);
    chk("rst_done", o_done, 0);
    chk("rst_busy", o_busy, 1);

    // Table vectors: one fresh start per vector.
    for (int v = 0; v < 8; v++) begin
      do_reset(vt[v].prev);
      load_cfg(vt[v].cfg, 0);
      i_trig = vt[v].nxt;
      mprev = vt[v].nxt;
      tick();
      chk($sformatf("vec%0d_valid", v), bus.m_o_valid, vt[v].exp_valid);
      if (vt[v].exp_valid) begin
        chk($sformatf("vec%0d_src", v), o_src_id, vt[v].exp_src);
        chk($sformatf("vec%0d_addr", v), bus.m_o_addr, vt[v].exp_addr);
        chk($sformatf("vec%0d_wdata", v), bus.m_o_wr_data, vt[v].exp_wd);
        chk($sformatf("vec%0d_rw", v), bus.m_o_rd0_wr1, vt[v].exp_rw);
        complete(vt[v].exp_addr, vt[v].exp_wd, vt[v].exp_rw, 0, 0, vt[v].rdata, vt[v].exp_src);
      end
    end

    // Priority follow-up: the losing source 4 only comes back when edges are remembered.
    do_reset(4'h0);
    c = '0;
    c[1] = mk(1,1,1,8'h11,16'h1111);
    c[3] = mk(1,1,1,8'h33,16'h3333);
    load_cfg(c, 0);
    run_action(4'hA, 0, 0, 32'h0, acted);
    load_cfg(c, 0);
    run_action(4'hA, 0, 0, 32'h0, acted);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("prio_no_extra", bus.m_o_valid, 0);
    end

    // Disabled source, stray ready, then a backpressured write.
    do_reset(4'h0);
    c = '0;
    c[0] = mk(0,1,1,8'hEE,16'hEEEE);
    c[1] = mk(1,1,1,8'h5A,16'hA5A5);
    load_cfg(c, 0);
    run_action(4'h1, 0, 0, 32'h0, acted);
    run_action(4'h0, 0, 0, 32'h0, acted);
    bus.m_i_ready = 1'b1;
    tick();
    bus.m_i_ready = 1'b0;
    chk("stray_ready_armed", o_busy, 0);
    chk("stray_ready_no_req", bus.m_o_valid, 0);
    run_action(4'h2, 5, 0, 32'h0, acted);

    // Config stall of 3 cycles, then a read with delayed return.
    do_reset(4'h0);
    c = '0;
    c[2] = mk(1,1,0,8'h77,16'h0);
    load_cfg(c, 3);
    run_action(4'h4, 2, 3, 32'h0BADF00D, acted);

    // Reset in the middle of ISSUE.
    do_reset(4'h0);
    c = '0;
    c[0] = mk(1,1,1,8'h44,16'h4444);
    load_cfg(c, 0);
    i_trig = 4'h1;
    tick();
    chk("mid_issue_valid", bus.m_o_valid, 1);
    tick();
    i_rstn = 1'b0;
    tick();
    chk("mid_rst_valid", bus.m_o_valid, 0);
    chk("mid_rst_addr", bus.m_o_addr, 0);
    chk("mid_rst_wdata", bus.m_o_wr_data, 0);
    chk("mid_rst_done", o_done, 0);
    chk("mid_rst_idle", reg_rd_en, 0);
    chk("mid_rst_busy", o_busy, 1);
    i_rstn = 1'b1;
    tick();
    chk("mid_rst_load", reg_rd_en, 1);
    chk("mid_rst_no_done", o_done, 0);

    // Reload in the same cycle as an edge: reload wins.
    do_reset(4'h0);
    c = '0;
    c[0] = mk(1,1,1,8'h66,16'h6666);
    load_cfg(c, 0);
    i_cfg_reload = 1'b1;
    i_trig = 4'h1;
    mprev = 4'h1;
`ifdef GP_TRIG_PEND_EN
    mpend[0] = 1'b1;
`endif
    tick();
    i_cfg_reload = 1'b0;
    chk("reload_no_valid", bus.m_o_valid, 0);
    chk("reload_to_load", reg_rd_en, 1);
    load_cfg(c, 0);
    run_action(4'h1, 0, 0, 32'h0, acted);

    // Randomised configs, triggers and slave timing against the reference rules.
    do_reset(4'h0);
    for (int it = 0; it < 150; it++) begin
      for (int i = 0; i < 4; i++) begin
        c[i] = $urandom;
        c[i][31] = ($urandom_range(0, 3) != 0);
      end
      load_cfg(c, $urandom_range(0, 3));
      acted = 0;
      for (int a = 0; a < 6 && !acted; a++)
        run_action(4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom, acted);
      if (!acted) begin
        i_cfg_reload = 1'b1;
        tick();
        i_cfg_reload = 1'b0;
        chk("rand_reload", reg_rd_en, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
